// File: rtl/matrix_job_sched.sv
// Matrix job scheduler: queues A/B/C descriptors and drives a memory-mapped
// matrix accelerator over a valid/ready master bus, one job at a time.
module matrix_job_sched #(
    parameter int          M          = 4,
    parameter int          N          = 4,
    parameter int          P          = 4,
    parameter logic [31:0] ACCEL_BASE = 32'h1000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          POLL_MAX   = 1024,
    parameter int          START_GAP  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        job_valid,
    output logic        job_ready,
    input  logic [31:0] job_a_addr,
    input  logic [31:0] job_b_addr,
    input  logic [31:0] job_c_addr,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata,
    output logic        busy,
    output logic        cpl_valid,
    output logic        cpl_err,
    output logic [15:0] jobs_done
);

    localparam int A_CNT   = M * N;
    localparam int B_CNT   = N * P;
    localparam int C_CNT   = M * P;
    localparam int MAX_AB  = (A_CNT > B_CNT) ? A_CNT : B_CNT;
    localparam int MAX_CNT = (MAX_AB > C_CNT) ? MAX_AB : C_CNT;
    localparam int IDX_W   = $clog2(MAX_CNT + 1);
    localparam int PC_W    = $clog2(POLL_MAX + 1);
    localparam int GAP_W   = $clog2(START_GAP + 2);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [IDX_W-1:0] A_LAST    = IDX_W'(A_CNT - 1);
    localparam logic [IDX_W-1:0] B_LAST    = IDX_W'(B_CNT - 1);
    localparam logic [IDX_W-1:0] C_LAST    = IDX_W'(C_CNT - 1);
    localparam logic [PC_W-1:0]  POLL_LAST = PC_W'(POLL_MAX - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((START_GAP > 0) ? START_GAP - 1 : 0);
    localparam logic [CNT_W-1:0] FIFO_FULL = CNT_W'(FIFO_DEPTH);
    localparam logic [31:0]      B_DST     = ACCEL_BASE + 32'h0000_0040;
    localparam logic [31:0]      C_SRC     = ACCEL_BASE + 32'h0000_0080;
    localparam logic [31:0]      CTRL_ADDR = ACCEL_BASE + 32'h0000_0100;
    localparam logic [31:0]      STAT_ADDR = ACCEL_BASE + 32'h0000_0104;

    typedef enum logic [3:0] {
        IDLE, LOAD_A, LOAD_B, KICK, GAP, POLL, STORE_C, RECOVER, CPL
    } state_t;

    logic [31:0]      fifo_a_r [FIFO_DEPTH];
    logic [31:0]      fifo_b_r [FIFO_DEPTH];
    logic [31:0]      fifo_c_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s, pop_s;

    state_t           state_r, next_s;
    logic [31:0]      cur_a_r, cur_b_r, cur_c_r, data_r;
    logic [IDX_W-1:0] idx_r, last_s;
    logic             phase_r;
    logic [PC_W-1:0]  poll_cnt_r;
    logic [GAP_W-1:0] gap_cnt_r;
    logic             m_valid_r, cpl_valid_r, cpl_err_r;
    logic [31:0]      m_addr_r, m_wdata_r, off_s, req_addr_s, req_wdata_s;
    logic [3:0]       m_wstrb_r, req_wstrb_s;
    logic [15:0]      jobs_done_r;

    assign job_ready = (count_r != FIFO_FULL);
    assign push_s    = job_valid && job_ready;
    assign pop_s     = (state_r == IDLE) && (count_r != {CNT_W{1'b0}});
    assign busy      = (state_r != IDLE) || (count_r != {CNT_W{1'b0}});
    assign m_valid   = m_valid_r;
    assign m_addr    = m_addr_r;
    assign m_wdata   = m_wdata_r;
    assign m_wstrb   = m_wstrb_r;
    assign cpl_valid = cpl_valid_r;
    assign cpl_err   = cpl_err_r;
    assign jobs_done = jobs_done_r;

    // Descriptor queue storage and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                fifo_a_r[wr_ptr_r] <= job_a_addr;
                fifo_b_r[wr_ptr_r] <= job_b_addr;
                fifo_c_r[wr_ptr_r] <= job_c_addr;
                wr_ptr_r           <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Bus request for the current state; phase 0 is the read half of a copy
    always_comb begin
        off_s       = 32'(idx_r) << 2;
        req_addr_s  = 32'h0;
        req_wdata_s = 32'h0;
        req_wstrb_s = 4'h0;
        last_s      = {IDX_W{1'b0}};
        next_s      = IDLE;
        case (state_r)
            LOAD_A: begin
                req_addr_s  = phase_r ? (ACCEL_BASE + off_s) : (cur_a_r + off_s);
                req_wdata_s = phase_r ? data_r : 32'h0;
                req_wstrb_s = phase_r ? 4'hF : 4'h0;
                last_s      = A_LAST;
                next_s      = LOAD_B;
            end
            LOAD_B: begin
                req_addr_s  = phase_r ? (B_DST + off_s) : (cur_b_r + off_s);
                req_wdata_s = phase_r ? data_r : 32'h0;
                req_wstrb_s = phase_r ? 4'hF : 4'h0;
                last_s      = B_LAST;
                next_s      = KICK;
            end
            STORE_C: begin
                req_addr_s  = phase_r ? (cur_c_r + off_s) : (C_SRC + off_s);
                req_wdata_s = phase_r ? data_r : 32'h0;
                req_wstrb_s = phase_r ? 4'hF : 4'h0;
                last_s      = C_LAST;
                next_s      = CPL;
            end
            KICK: begin
                req_addr_s  = CTRL_ADDR;
                req_wdata_s = 32'h1;
                req_wstrb_s = 4'hF;
            end
            POLL: begin
                req_addr_s  = STAT_ADDR;
            end
            RECOVER: begin
                req_addr_s  = CTRL_ADDR;
                req_wdata_s = phase_r ? 32'h0 : 32'h2;
                req_wstrb_s = 4'hF;
            end
            default: next_s = IDLE;
        endcase
    end

    // Job sequencer: transfers, polling, recovery and completion reporting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cur_a_r     <= 32'h0;
            cur_b_r     <= 32'h0;
            cur_c_r     <= 32'h0;
            data_r      <= 32'h0;
            idx_r       <= {IDX_W{1'b0}};
            phase_r     <= 1'b0;
            poll_cnt_r  <= {PC_W{1'b0}};
            gap_cnt_r   <= {GAP_W{1'b0}};
            m_valid_r   <= 1'b0;
            m_addr_r    <= 32'h0;
            m_wdata_r   <= 32'h0;
            m_wstrb_r   <= 4'h0;
            cpl_valid_r <= 1'b0;
            cpl_err_r   <= 1'b0;
            jobs_done_r <= 16'h0;
        end else begin
            cpl_valid_r <= 1'b0;
            cpl_err_r   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pop_s) begin
                        cur_a_r <= fifo_a_r[rd_ptr_r];
                        cur_b_r <= fifo_b_r[rd_ptr_r];
                        cur_c_r <= fifo_c_r[rd_ptr_r];
                        idx_r   <= {IDX_W{1'b0}};
                        phase_r <= 1'b0;
                        state_r <= LOAD_A;
                    end
                end
                GAP: begin
                    // The last idle cycle already launches the first status read
                    if (gap_cnt_r == GAP_LAST) begin
                        m_valid_r <= 1'b1;
                        m_addr_r  <= STAT_ADDR;
                        m_wdata_r <= 32'h0;
                        m_wstrb_r <= 4'h0;
                        state_r   <= POLL;
                    end else begin
                        gap_cnt_r <= gap_cnt_r + GAP_W'(1'b1);
                    end
                end
                CPL: state_r <= IDLE;
                LOAD_A, LOAD_B, KICK, POLL, STORE_C, RECOVER: begin
                    if (!m_valid_r) begin
                        m_valid_r <= 1'b1;
                        m_addr_r  <= req_addr_s;
                        m_wdata_r <= req_wdata_s;
                        m_wstrb_r <= req_wstrb_s;
                    end else if (m_ready) begin
                        m_valid_r <= 1'b0;
                        if (!phase_r) begin
                            data_r <= m_rdata;
                        end
                        case (state_r)
                            KICK: begin
                                poll_cnt_r <= {PC_W{1'b0}};
                                gap_cnt_r  <= {GAP_W{1'b0}};
                                state_r    <= (START_GAP > 0) ? GAP : POLL;
                            end
                            POLL: begin
                                if (m_rdata[1]) begin
                                    idx_r   <= {IDX_W{1'b0}};
                                    state_r <= STORE_C;
                                end else if (poll_cnt_r == POLL_LAST) begin
                                    state_r <= RECOVER;
                                end else begin
                                    poll_cnt_r <= poll_cnt_r + PC_W'(1'b1);
                                end
                            end
                            RECOVER: begin
                                if (phase_r) begin
                                    phase_r     <= 1'b0;
                                    cpl_valid_r <= 1'b1;
                                    cpl_err_r   <= 1'b1;
                                    jobs_done_r <= jobs_done_r + 16'd1;
                                    state_r     <= CPL;
                                end else begin
                                    phase_r <= 1'b1;
                                end
                            end
                            default: begin
                                if (!phase_r) begin
                                    phase_r <= 1'b1;
                                end else begin
                                    phase_r <= 1'b0;
                                    if (idx_r == last_s) begin
                                        idx_r   <= {IDX_W{1'b0}};
                                        state_r <= next_s;
                                        if (state_r == STORE_C) begin
                                            cpl_valid_r <= 1'b1;
                                            jobs_done_r <= jobs_done_r + 16'd1;
                                        end
                                    end else begin
                                        idx_r <= idx_r + IDX_W'(1'b1);
                                    end
                                end
                            end
                        endcase
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/matrix_job_sched.md
MATRIX_JOB_SCHED -- requirements
Module: matrix_job_sched

Interface
REQ-001 SHALL have parameters: M, default 4, rows of A/C; N, default 4, cols of A/rows of B; P, default 4, cols of B/C; ACCEL_BASE, default 32'h10000000, accelerator base address; FIFO_DEPTH, default 4, job queue entries (power of 2); POLL_MAX, default 1024, status reads before timeout; START_GAP, default 2, idle cycles between start write and first poll.
REQ-002 SHALL have ports, with reset rst_n synchronous active-low and clock clk:
  clk  in  1  clock
  rst_n  in  1  synchronous active-low reset
  job_valid  in  1  job descriptor offered
  job_ready  out  1  queue can accept
  job_a_addr  in  32  word-aligned system address of A (M*N words)
  job_b_addr  in  32  word-aligned system address of B (N*P words)
  job_c_addr  in  32  word-aligned system destination of C (M*P words)
  m_valid  out  1  master bus request
  m_ready  in  1  bus completes transfer
  m_addr  out  32  bus address
  m_wdata  out  32  write data
  m_wstrb  out  4  4'hF write, 4'h0 read
  m_rdata  in  32  read data, valid when m_valid&&m_ready
  busy  out  1  job in progress or queue non-empty
  cpl_valid  out  1  one-cycle job-completion pulse
  cpl_err  out  1  qualifies cpl_valid: job timed out
  jobs_done  out  16  count of completed jobs, wraps

Function
REQ-003 SHALL queue descriptors in a FIFO_DEPTH-entry FIFO; push when job_valid&&job_ready; job_ready = !full; jobs execute in order.
REQ-004 SHALL keep m_valid and m_addr/m_wdata/m_wstrb stable until m_ready sampled high; the transfer completes in that cycle; m_valid SHALL be low at least one cycle between transfers.
REQ-005 SHALL use states IDLE, LOAD_A, LOAD_B, KICK, GAP, POLL, STORE_C, RECOVER, CPL.
REQ-006 IDLE: when FIFO non-empty, pop head into working registers, clear element index, go LOAD_A in the next cycle.
REQ-007 LOAD_A: for i=0..M*N-1, read job_a_addr+4i, then write the full 32-bit word read to ACCEL_BASE+4i; after the last write go LOAD_B.
REQ-008 LOAD_B: same for i=0..N*P-1, source job_b_addr+4i, destination ACCEL_BASE+0x40+4i; then KICK.
REQ-009 KICK: write 32'h1 to ACCEL_BASE+0x100; then GAP for START_GAP cycles with m_valid low; then POLL.
REQ-010 POLL: read ACCEL_BASE+0x104; if rdata[1]=1 go STORE_C; else increment poll count and reissue; when POLL_MAX reads complete without rdata[1]=1, go RECOVER.
REQ-011 STORE_C: for i=0..M*P-1, read ACCEL_BASE+0x80+4i, then write the word to job_c_addr+4i; then CPL with cpl_err=0.
REQ-012 RECOVER: write 32'h2 then 32'h0 to ACCEL_BASE+0x100; no C transfer; then CPL with cpl_err=1.
REQ-013 CPL: assert cpl_valid for exactly one cycle, cpl_err as set; increment jobs_done (both outcomes, 16'hFFFF wraps to 0); return to IDLE.
REQ-014 Address arithmetic SHALL be 32-bit modulo 2^32; element index and poll count sized for their maxima.
REQ-015 busy = (state!=IDLE) || FIFO non-empty.
REQ-016 A push in the same cycle as a pop SHALL be accepted when the FIFO is not full before the cycle; occupancy is unchanged.
REQ-017 cpl_err SHALL be 0 whenever cpl_valid is 0.
REQ-018 Descriptor inputs SHALL NOT affect an in-flight job.

Reset
REQ-019 rst_n low at any clock edge, including mid-transfer, SHALL empty the FIFO, abort the job without completion, and enter IDLE; outputs: job_ready=1, m_valid=0, m_addr=0, m_wdata=0, m_wstrb=0, busy=0, cpl_valid=0, cpl_err=0, jobs_done=0.

Verification
REQ-020 One job (A=0x2000, B=0x3000, C=0x4000), m_ready always 1, status bit1=1 on 3rd poll -> exactly 16+16 reads/writes in order, write 0x1 to 0x10000100, 3 polls, 16 C copies to 0x4000..0x403C, one cpl_valid with cpl_err=0, jobs_done=1.
REQ-021 Random m_ready stalls 0-5 cycles -> identical transfer sequence and data to REQ-020; request fields never change while m_valid=1 and m_ready=0.
REQ-022 Push 5 jobs back-to-back with FIFO_DEPTH=4 while the first is executing -> job_ready low when full, all jobs complete in push order, jobs_done=5.
REQ-023 Status bit1 never set, POLL_MAX=8 -> 8 polls, writes 0x2 then 0x0 to 0x10000100, no C transfers, cpl_valid with cpl_err=1, next queued job runs normally.
REQ-024 Assert rst_n low during LOAD_B with 2 jobs queued -> next cycle m_valid=0, busy=0, jobs_done=0, no cpl_valid, no further bus activity.
REQ-025 jobs_done preset scenario: complete 65537 jobs (short stub) -> jobs_done=1.
